// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types, widths and helpers for the Simon game controller
package simon_pkg;

  localparam int COLOR_W     = 2;
  localparam int MAX_LEN_DEF = 16;
  localparam int LEVEL_W     = 6;
  localparam int NUM_BTN     = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  // Largest of three cycle counts; sizes the shared delay counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Number of buttons that rose in the same cycle.
  function automatic logic [2:0] count_ones(input logic [NUM_BTN-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Colour index of a one-hot button vector (lowest set bit wins).
  function automatic logic [COLOR_W-1:0] onehot_to_color(input logic [NUM_BTN-1:0] v);
    logic [COLOR_W-1:0] c;
    c = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) c = COLOR_W'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// rtl/simon_seq_mem.sv - colour sequence register file, one sync write port, one async read port
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int DEPTH = MAX_LEN_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [COLOR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [COLOR_W-1:0] rdata_o
);

  logic [COLOR_W-1:0] mem_q [DEPTH];

  // Storage: every entry cleared by reset, single write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simon_game_ctrl.sv
// rtl/simon_game_ctrl.sv - Simon game FSM; SIMON_TIMEOUT_EN enables the per-press input timeout
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEF,
  parameter int SHOW_CYCLES    = 12_000_000,
  parameter int GAP_CYCLES     = 6_000_000,
  parameter int TIMEOUT_CYCLES = 60_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_BTN-1:0] btn,
  input  logic [7:0]         lfsr_value,
  input  logic               lfsr_done,
  output logic               lfsr_en,
  output logic [NUM_BTN-1:0] led,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               game_over,
  output logic               win
);

  localparam int MAX_CNT = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0]   SHOW_LD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEN_FULL = LEVEL_W'(MAX_LEN);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0]   TOUT_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_e               state_q, state_d;
  logic [LEVEL_W-1:0]   len_q, len_d;
  logic [LEVEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 start_q;
  logic [NUM_BTN-1:0]   btn_q;

  logic                 start_rise;
  logic [NUM_BTN-1:0]   btn_rise;
  logic [2:0]           rise_cnt;
  logic                 press;
  logic                 multi_press;
  logic [COLOR_W-1:0]   press_color;

  logic                 mem_we;
  logic [COLOR_W-1:0]   cur_color;
  logic                 reload;
  logic                 unused_lfsr_bits;

  assign start_rise  = start & ~start_q;
  assign btn_rise    = btn & ~btn_q;
  assign rise_cnt    = count_ones(btn_rise);
  assign press       = (rise_cnt == 3'd1);
  assign multi_press = (rise_cnt > 3'd1);
  assign press_color = onehot_to_color(btn_rise);

  // Only the low colour bits of the random value are meaningful.
  assign unused_lfsr_bits = ^lfsr_value[7:COLOR_W];

  simon_seq_mem #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_seq_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (len_q[AW-1:0]),
    .wdata_i (lfsr_value[COLOR_W-1:0]),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (cur_color)
  );

  // Delay value loaded whenever a state is (re)entered.
  function automatic logic [CNT_W-1:0] load_val(input state_e s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      ST_SHOW_ON:  v = SHOW_LD;
      ST_SHOW_OFF: v = GAP_LD;
`ifdef SIMON_TIMEOUT_EN
      ST_INPUT:    v = TOUT_LD;
`endif
      default:     v = '0;
    endcase
    return v;
  endfunction

  // Next-state logic for the game flow, sequence length, step index and delay counter.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    reload  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start_rise) begin
          len_d   = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        if (lfsr_done) begin
          mem_we  = 1'b1;
          len_d   = len_q + LEVEL_W'(1);
          idx_d   = '0;
          state_d = ST_SHOW_ON;
        end
      end
      ST_SHOW_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_SHOW_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (cnt_q == '0) begin
          if ((idx_q + LEVEL_W'(1)) < len_q) begin
            idx_d   = idx_q + LEVEL_W'(1);
            state_d = ST_SHOW_ON;
          end else begin
            idx_d   = '0;
            state_d = ST_INPUT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_INPUT: begin
        if (multi_press) begin
          state_d = ST_LOSE;
        end else if (press) begin
          if (press_color != cur_color) begin
            state_d = ST_LOSE;
          end else if ((idx_q + LEVEL_W'(1)) < len_q) begin
            idx_d  = idx_q + LEVEL_W'(1);
            reload = 1'b1;
          end else if (len_q == LEN_FULL) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_GEN;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = ST_LOSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d != state_q) || reload) begin
      cnt_d = load_val(state_d);
    end
  end

  // State, counters and edge-detect history; reset aborts any game immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      start_q <= start;
      btn_q   <= btn;
    end
  end

  // Display and status outputs decoded from the current state.
  always_comb begin
    led       = '0;
    lfsr_en   = 1'b0;
    busy      = 1'b0;
    game_over = 1'b0;
    win       = 1'b0;
    case (state_q)
      ST_GEN: begin
        lfsr_en = 1'b1;
        busy    = 1'b1;
      end
      ST_SHOW_ON: begin
        led  = NUM_BTN'(1) << cur_color;
        busy = 1'b1;
      end
      ST_SHOW_OFF: busy = 1'b1;
      ST_INPUT:    led = btn;
      ST_WIN: begin
        led = 4'b1111;
        win = 1'b1;
      end
      ST_LOSE:     game_over = 1'b1;
      default:     led = '0;
    endcase
  end

  assign level = len_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb/tb_simon_game_ctrl.sv - directed self-checking bench for simon_game_ctrl
module tb_simon_game_ctrl;
  import simon_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] btn;
  logic [7:0] lfsr_value;
  logic       lfsr_done;
  logic       lfsr_en;
  logic [3:0] led;
  logic [5:0] level;
  logic       busy;
  logic       game_over;
  logic       win;

  int checks;
  int errors;

  logic [1:0] exp_seq [4];
  logic [7:0] rnd_val [4];

  simon_game_ctrl #(
    .MAX_LEN        (4),
    .SHOW_CYCLES    (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .btn        (btn),
    .lfsr_value (lfsr_value),
    .lfsr_done  (lfsr_done),
    .lfsr_en    (lfsr_en),
    .led        (led),
    .level      (level),
    .busy       (busy),
    .game_over  (game_over),
    .win        (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input state_e s);
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  // Deliver one random value while in GEN.
  task automatic feed(input logic [7:0] v);
    lfsr_value = v;
    lfsr_done  = 1'b1;
    tick();
    lfsr_done  = 1'b0;
  endtask

  // Walk the display phase for n steps and land in INPUT.
  task automatic show(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        check("show_on_led", 32'(led), 32'(4'b0001 << exp_seq[i]));
        tick();
      end
      for (int k = 0; k < 2; k++) begin
        check("show_off_led", 32'(led), 32'h0);
        check("show_off_busy", 32'(busy), 32'h1);
        tick();
      end
    end
    chk_state("show_end_input", ST_INPUT);
    check("input_busy", 32'(busy), 32'h0);
  endtask

  task automatic start_edge();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_seq[0] = 2'd2; exp_seq[1] = 2'd0; exp_seq[2] = 2'd3; exp_seq[3] = 2'd1;
    rnd_val[0] = 8'h06; rnd_val[1] = 8'h04; rnd_val[2] = 8'h0F; rnd_val[3] = 8'h11;
    rst = 1'b1; start = 1'b0; btn = 4'b0; lfsr_value = 8'h0; lfsr_done = 1'b0;
    tick();
    tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_status", 32'({lfsr_en, busy, game_over, win}), 32'h0);
    chk_state("rst_state", ST_IDLE);
    rst = 1'b0;
    tick();

    // Reset in the middle of the display phase.
    start_edge();
    chk_state("gen_entry", ST_GEN);
    check("gen_lfsr_en", 32'(lfsr_en), 32'h1);
    feed(8'h06);
    tick();
    check("mid_show_led", 32'(led), 32'b0100);
    rst = 1'b1;
    #1;
    check("rst_mid_led", 32'(led), 32'h0);
    check("rst_mid_level", 32'(level), 32'h0);
    check("rst_mid_status", 32'({lfsr_en, busy, game_over, win}), 32'h0);
    chk_state("rst_mid_state", ST_IDLE);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk_state("idle_hold", ST_IDLE);
    check("idle_busy", 32'(busy), 32'h0);

    // Full correct game of {2,0,3,1}.
    start_edge();
    chk_state("game_gen", ST_GEN);
    check("game_level0", 32'(level), 32'h0);
    check("game_busy", 32'(busy), 32'h1);
    for (int r = 0; r < 4; r++) begin
      check("pre_feed_lfsr_en", 32'(lfsr_en), 32'h1);
      feed(rnd_val[r]);
      check("round_level", 32'(level), 32'(r + 1));
      check("show_lfsr_en", 32'(lfsr_en), 32'h0);
      show(r + 1);
      for (int i = 0; i <= r; i++) begin
        btn = 4'b0001 << exp_seq[i];
        #1;
        check("input_led_btn", 32'(led), 32'(btn));
        tick();
        btn = 4'b0;
        if (i < r) begin
          chk_state("press_stay", ST_INPUT);
        end else if (r < 3) begin
          chk_state("round_done_gen", ST_GEN);
          check("round_done_level", 32'(level), 32'(r + 1));
        end else begin
          check("win_flag", 32'(win), 32'h1);
          check("win_led", 32'(led), 32'hF);
          check("win_level", 32'(level), 32'h4);
        end
        tick();
      end
    end
    repeat (3) tick();
    check("win_hold", 32'(win), 32'h1);

    // Wrong colour, then restart.
    start_edge();
    chk_state("restart_gen", ST_GEN);
    check("restart_level", 32'(level), 32'h0);
    feed(8'h06);
    show(1);
    btn = 4'b0001;
    tick();
    btn = 4'b0;
    check("wrong_game_over", 32'(game_over), 32'h1);
    check("lose_led", 32'(led), 32'h0);
    repeat (3) tick();
    chk_state("lose_hold", ST_LOSE);
    start_edge();
    check("lose_restart_level", 32'(level), 32'h0);
    chk_state("lose_restart_gen", ST_GEN);

    // Stray lfsr_done in INPUT, then two buttons at once.
    feed(8'h06);
    show(1);
    feed(8'h03);
    check("stray_done_level", 32'(level), 32'h1);
    chk_state("stray_done_state", ST_INPUT);
    btn = 4'b0011;
    tick();
    btn = 4'b0;
    chk_state("multi_lose", ST_LOSE);
    check("multi_game_over", 32'(game_over), 32'h1);

    // Idle player in INPUT.
    start_edge();
    feed(8'h06);
    show(1);
`ifdef SIMON_TIMEOUT_EN
    repeat (19) tick();
    chk_state("timeout_edge_input", ST_INPUT);
    tick();
    chk_state("timeout_lose", ST_LOSE);
`else
    repeat (100) tick();
    chk_state("no_timeout_input", ST_INPUT);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
